// File: rtl/img_pix_pkg.sv
// Shared constants and state encoding for the image pixel server.
package img_pix_pkg;

    localparam int unsigned DATA_W     = 10;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned FRAME_PIX  = 76800;
    localparam int unsigned RDY_THRESH = 512;
    localparam int unsigned CNT_W      = $clog2(FRAME_PIX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

endpackage

// File: rtl/img_pix_server_fifo.sv
// Synchronous single-clock FIFO with registered read data and an occupancy count.
module pix_fifo #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/img_pix_server.sv
// Buffers a camera pixel stream and serves it one pixel per reader request.
// Optional build macro IMG_PIX_SERVER_TESTPAT_EN adds a test_pat ramp override input.
module img_pix_server #(
    parameter int unsigned DATA_W     = img_pix_pkg::DATA_W,
    parameter int unsigned DEPTH      = img_pix_pkg::DEPTH,
    parameter int unsigned FRAME_PIX  = img_pix_pkg::FRAME_PIX,
    parameter int unsigned RDY_THRESH = img_pix_pkg::RDY_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              cam_sof,
`ifdef IMG_PIX_SERVER_TESTPAT_EN
    input  logic              test_pat,
`endif
    input  logic              vga2_req,
    output logic [DATA_W-1:0] rd2_data,
    output logic              pix_rdy,
    output logic              frame_done,
    output logic              overflow,
    output logic              underflow
);
    import img_pix_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  wr_cnt_next;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rd_cnt_next;
    logic              wr_open;
    logic              wr_take;
    logic              push;
    logic              pop;
    logic              of_evt;
    logic              uf_evt;
    logic              frame_end;
    logic              rdy_next;
    logic              pop_d;
    logic              uf_d;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     level;
    logic [LW-1:0]     level_next;

    // A write is counted when it belongs to the current frame, even if the FIFO drops it.
    always_comb begin
        wr_open = 1'b0;
        if (state == ST_IDLE) begin
            wr_open = cam_sof;
        end else begin
            wr_open = (wr_cnt < CNT_W'(FRAME_PIX));
        end
        wr_take    = cam_valid && wr_open;
        push       = wr_take && !fifo_full;
        of_evt     = wr_take && fifo_full;
        pop        = vga2_req && pix_rdy && !fifo_empty;
        uf_evt     = vga2_req && !pop;
        level_next = level + LW'(push) - LW'(pop);
    end

`ifdef IMG_PIX_SERVER_TESTPAT_EN
    assign wr_data = test_pat ? wr_cnt[DATA_W-1:0] : cam_data;
`else
    assign wr_data = cam_data;
`endif

    pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Frame sequencing: next state, counters and ready.
    always_comb begin
        state_next  = state;
        wr_cnt_next = wr_cnt;
        rd_cnt_next = rd_cnt;
        frame_end   = 1'b0;
        rdy_next    = 1'b0;

        if (wr_take) begin
            wr_cnt_next = wr_cnt + CNT_W'(1);
        end
        if (pop) begin
            rd_cnt_next = rd_cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (wr_take) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if ((level_next >= LW'(RDY_THRESH)) ||
                    (wr_cnt_next == CNT_W'(FRAME_PIX))) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (rd_cnt_next == CNT_W'(FRAME_PIX)) begin
                    frame_end   = 1'b1;
                    state_next  = ST_IDLE;
                    wr_cnt_next = '0;
                    rd_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        rdy_next = (state_next == ST_SERVE) && (level_next != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            pix_rdy    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            pop_d      <= 1'b0;
            uf_d       <= 1'b0;
            rd2_data   <= '0;
        end else begin
            state      <= state_next;
            wr_cnt     <= wr_cnt_next;
            rd_cnt     <= rd_cnt_next;
            pix_rdy    <= rdy_next;
            frame_done <= frame_end;
            overflow   <= overflow | of_evt;
            underflow  <= underflow | uf_evt;
            pop_d      <= pop;
            uf_d       <= uf_evt;
            // FIFO dout lands one edge after the pop; forward it, or zero on a refused request.
            if (pop_d) begin
                rd2_data <= fifo_dout;
            end else if (uf_d) begin
                rd2_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_img_pix_server.sv
// Scoreboard bench for img_pix_server with a small frame and a four-entry FIFO.
module tb_img_pix_server;

    localparam int unsigned DW    = 10;
    localparam int unsigned DEP   = 4;
    localparam int unsigned FRAME = 8;
    localparam int unsigned TH    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cam_valid = 1'b0;
    logic [DW-1:0] cam_data = '0;
    logic          cam_sof = 1'b0;
    logic          vga2_req = 1'b0;
    logic [DW-1:0] rd2_data;
    logic          pix_rdy;
    logic          frame_done;
    logic          overflow;
    logic          underflow;
`ifdef IMG_PIX_SERVER_TESTPAT_EN
    logic          test_pat = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            m_state = 0;
    int            m_level = 0;
    int            m_wr = 0;
    int            m_rd = 0;
    bit            m_rdy = 0;
    bit            m_of = 0;
    bit            m_uf = 0;
    bit            m_pat = 0;
    logic [DW-1:0] m_rd2 = '0;
    logic [DW-1:0] exp_q[$];

    img_pix_server #(
        .DATA_W     (DW),
        .DEPTH      (DEP),
        .FRAME_PIX  (FRAME),
        .RDY_THRESH (TH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cam_valid  (cam_valid),
        .cam_data   (cam_data),
        .cam_sof    (cam_sof),
`ifdef IMG_PIX_SERVER_TESTPAT_EN
        .test_pat   (test_pat),
`endif
        .vga2_req   (vga2_req),
        .rd2_data   (rd2_data),
        .pix_rdy    (pix_rdy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One bus cycle starting at a negedge; for a request, waits one more cycle for rd2_data.
    task automatic cycle(input bit valid, input logic [DW-1:0] d, input bit sof, input bit req);
        bit            take;
        bit            popv;
        bit            fd;
        int            pre_level;
        logic [DW-1:0] val;
        logic [DW-1:0] exp_rd;

        cam_valid = valid;
        cam_data  = d;
        cam_sof   = sof;
        vga2_req  = req;

        pre_level = m_level;
        fd        = 1'b0;
        exp_rd    = '0;
        take      = valid && ((m_state == 0) ? sof : (m_wr < int'(FRAME)));
        popv      = req && m_rdy;

        if (popv) begin
            exp_rd = exp_q.pop_front();
            m_level--;
        end else if (req) begin
            m_uf = 1'b1;
        end
        if (take) begin
            val = m_pat ? DW'(m_wr) : d;
            if (pre_level < int'(DEP)) begin
                exp_q.push_back(val);
                m_level++;
            end else begin
                m_of = 1'b1;
            end
            m_wr++;
        end

        if (m_state == 0) begin
            if (take) m_state = 1;
        end else if (m_state == 1) begin
            if (m_level >= int'(TH) || m_wr == int'(FRAME)) m_state = 2;
        end else if (popv) begin
            m_rd++;
            if (m_rd == int'(FRAME)) begin
                fd      = 1'b1;
                m_state = 0;
                m_wr    = 0;
                m_rd    = 0;
            end
        end
        m_rdy = (m_state == 2) && (m_level != 0);

        @(posedge clk);
        @(negedge clk);
        cam_valid = 1'b0;
        cam_sof   = 1'b0;
        vga2_req  = 1'b0;
        check("pix_rdy", 32'(pix_rdy), 32'(m_rdy));
        check("frame_done", 32'(frame_done), 32'(fd));
        check("overflow", 32'(overflow), 32'(m_of));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("fifo_level", 32'(dut.u_fifo.level), 32'(m_level));
        check("rd2_hold", 32'(rd2_data), 32'(m_rd2));

        if (req) begin
            m_rd2 = exp_rd;
            @(posedge clk);
            @(negedge clk);
            check("rd2_data", 32'(rd2_data), 32'(m_rd2));
            check("frame_done_end", 32'(frame_done), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_rd2_data", 32'(rd2_data), 32'd0);
        check("rst_pix_rdy", 32'(pix_rdy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_level", 32'(dut.u_fifo.level), 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        m_state = 0;
        m_level = 0;
        m_wr    = 0;
        m_rd    = 0;
        m_rdy   = 1'b0;
        m_of    = 1'b0;
        m_uf    = 1'b0;
        m_rd2   = '0;
        exp_q.delete();
    endtask

    task automatic write_run(input int first, input int n, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, DW'(first + i), sof_first && (i == 0), 1'b0);
        end
    endtask

    task automatic read_run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        do_reset();

        // Request with nothing buffered
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Full frame 1..8 in two halves; underflow must stay sticky
        write_run(1, 4, 1'b1);
        read_run(4);
        write_run(5, 4, 1'b0);
        read_run(4);
        check("state_idle", 32'(dut.state), 32'd0);

        // Stray pixels in IDLE are ignored
        write_run(90, 2, 1'b0);

        // Overflow: six writes into four entries, then the frame tail
        do_reset();
        write_run(11, 6, 1'b1);
        read_run(4);
        write_run(17, 3, 1'b0);
        read_run(3);

        // Simultaneous push and pop at level 2
        do_reset();
        write_run(21, 4, 1'b1);
        read_run(2);
        cycle(1'b1, DW'(25), 1'b0, 1'b1);
        read_run(3);
        write_run(26, 3, 1'b0);
        read_run(3);

        // Reset mid-serve after three reads
        write_run(31, 4, 1'b1);
        read_run(3);
        do_reset();
        write_run(40, 2, 1'b0);
        write_run(41, 4, 1'b1);
        read_run(4);
        write_run(45, 4, 1'b0);
        read_run(4);

`ifdef IMG_PIX_SERVER_TESTPAT_EN
        // Ramp override ignores cam_data
        test_pat = 1'b1;
        m_pat    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DW'($urandom_range(1023, 0)), i == 0, 1'b0);
        end
        read_run(4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, DW'($urandom_range(1023, 0)), 1'b0, 1'b0);
        end
        read_run(4);
        test_pat = 1'b0;
        m_pat    = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
